// File: rtl/msk_rnd_prng_pkg.sv
// msk_rnd_pkg: shared widths, LFSR taps, FSM encoding and single-step LFSR helper for msk_rnd_prng
package msk_rnd_pkg;
  localparam int STATE_W = 128;
  localparam int SEED_W = 32;
  localparam int SEED_WORDS = 4;
  localparam int TAP0 = 127;
  localparam int TAP1 = 125;
  localparam int TAP2 = 100;
  localparam int TAP3 = 98;
  typedef enum logic [1:0] {SEED, WARM, RUN} fsm_e;
  function automatic logic [STATE_W-1:0] lfsr_step(input logic [STATE_W-1:0] s);
    return {s[STATE_W-2:0], s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]};
  endfunction
endpackage

// File: rtl/msk_rnd_prng_if.sv
// msk_rnd_prng_if: seed and randomness valid/ready bus; master = seeder/consumer, slave = prng
interface msk_rnd_prng_if #(parameter int NRND = 4);
  logic [31:0]     seed_in;
  logic            seed_valid;
  logic            seed_ready;
  logic            reseed;
  logic [NRND-1:0] rnd_out;
  logic            rnd_valid;
  logic            rnd_ready;
  modport master(output seed_in, seed_valid, reseed, rnd_ready, input seed_ready, rnd_out, rnd_valid);
  modport slave(input seed_in, seed_valid, reseed, rnd_ready, output seed_ready, rnd_out, rnd_valid);
endinterface

// File: rtl/msk_rnd_prng_lfsr_unroll.sv
// prng_lfsr_unroll: combinational NRND-step advance of the 128-bit Fibonacci LFSR (s -> s_next)
module prng_lfsr_unroll
  import msk_rnd_pkg::*;
#(
  parameter int NRND = 4
) (
  input  logic [STATE_W-1:0] s,
  output logic [STATE_W-1:0] s_next
);
  logic [STATE_W-1:0] st [NRND+1];
  assign st[0] = s;
  for (genvar j = 0; j < NRND; j++) begin : g_step
    assign st[j+1] = lfsr_step(st[j]);
  end
  assign s_next = st[NRND];
endmodule

// File: rtl/msk_rnd_prng.sv
// msk_rnd_prng: seeded 128-bit LFSR delivering NRND fresh random bits per cycle to masked gadgets
// Ports: clk, rst (sync, active-high); bus (msk_rnd_prng_if.slave): seed_in/seed_valid/seed_ready,
// reseed pulse, rnd_out/rnd_valid/rnd_ready.
// Optional: define PRNG_OUTREG_EN to register rnd_out/rnd_valid (one extra cycle of latency).
module msk_rnd_prng
  import msk_rnd_pkg::*;
#(
  parameter int NRND   = 4,
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  msk_rnd_prng_if.slave     bus
);
  localparam int WW = $clog2(WARMUP + 2);
  fsm_e               state, state_n;
  logic [1:0]         word_cnt, word_cnt_n;
  logic [WW-1:0]      warm_cnt, warm_cnt_n;
  logic [STATE_W-1:0] lfsr, lfsr_n, lfsr_adv, seed_mix;
  logic               src_ready;
  prng_lfsr_unroll #(.NRND(NRND)) u_unroll (.s(lfsr), .s_next(lfsr_adv));
  // Splice the incoming word into its slot; an all-zero final seed would lock the LFSR, so force bit 0.
  always_comb begin
    seed_mix = lfsr;
    seed_mix[SEED_W*word_cnt +: SEED_W] = bus.seed_in;
    seed_mix[0] = seed_mix[0] | (word_cnt == 2'd3 && seed_mix == '0);
  end
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    warm_cnt_n = warm_cnt;
    lfsr_n     = lfsr;
    if (bus.reseed) begin
      state_n    = SEED;
      word_cnt_n = '0;
      lfsr_n     = '0;
    end else if (state == SEED) begin
      if (bus.seed_valid) begin
        lfsr_n     = seed_mix;
        word_cnt_n = word_cnt + 2'd1;
        if (word_cnt == 2'd3) begin
          state_n    = WARMUP == 0 ? RUN : WARM;
          warm_cnt_n = WW'(WARMUP == 0 ? 0 : WARMUP - 1);
        end
      end
    end else if (state == WARM) begin
      lfsr_n     = lfsr_adv;
      warm_cnt_n = warm_cnt - WW'(1);
      state_n    = warm_cnt == '0 ? RUN : WARM;
    end else if (src_ready) begin
      lfsr_n = lfsr_adv;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEED;
      word_cnt <= '0;
      warm_cnt <= '0;
      lfsr     <= '0;
    end else begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      warm_cnt <= warm_cnt_n;
      lfsr     <= lfsr_n;
    end
  end
  assign bus.seed_ready = state == SEED;
`ifdef PRNG_OUTREG_EN
  logic            out_valid;
  logic [NRND-1:0] out_data;
  // The LFSR only advances when the output slot is empty or being drained, so no value is lost.
  assign src_ready = !out_valid || bus.rnd_ready;
  always_ff @(posedge clk) begin
    if (rst || bus.reseed) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (src_ready) begin
      out_valid <= state == RUN;
      out_data  <= state == RUN ? lfsr_adv[NRND-1:0] : '0;
    end
  end
  assign bus.rnd_valid = out_valid;
  assign bus.rnd_out   = out_data;
`else
  assign src_ready     = bus.rnd_ready;
  assign bus.rnd_valid = state == RUN;
  assign bus.rnd_out   = state == RUN ? lfsr_adv[NRND-1:0] : '0;
`endif
endmodule
